// File: rtl/data_mem_ctrl.sv
// RISC-V data memory controller: byte-lane RAM behind valid/ready request and response
// channels, with configurable response latency and fault reporting.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter bit          INIT_ZERO   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault
);

  localparam int unsigned          AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned          CNT_W     = 4;
  localparam logic [31:0]          INIT_WORD = INIT_ZERO ? 32'h0 : 'x;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {
    F_OK       = 2'd0,
    F_MISALIGN = 2'd1,
    F_RANGE    = 2'd2,
    F_ILLEGAL  = 2'd3
  } fault_e;

  // Initial value only; the array is never touched by reset.
  logic [3:0][7:0] mem [DEPTH_WORDS] = '{default: INIT_WORD};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        rdata_q, rdata_d;
  fault_e             fault_q, fault_d;

  logic               accept;
  fault_e             req_fault;
  logic [AW-1:0]      word_idx;
  logic [1:0]         lane;
  logic [31:0]        rd_word;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        load_data;
  logic               mem_we;
  logic [3:0]         byte_en;
  logic [3:0][7:0]    wdata_rep;

  assign accept   = req_valid && req_ready_q;
  assign word_idx = req_addr[AW+1:2];
  assign lane     = req_addr[1:0];

  // Fault priority: illegal encoding, then range, then alignment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_fault = F_OK;
    if ((req_func3 inside {3'd3, 3'd6, 3'd7}) || (req_write && (req_func3 inside {3'd4, 3'd5})))
      req_fault = F_ILLEGAL;
    else if (|req_addr[31:AW+2])
      req_fault = F_RANGE;
    else if (((req_func3[1:0] == 2'b01) && req_addr[0]) || ((req_func3 == 3'd2) && (lane != 2'b00)))
      req_fault = F_MISALIGN;
  end

  always_comb begin
    rd_word = mem[word_idx];
    unique case (lane)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (req_func3)
      3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_data = {24'h0, byte_sel};
      3'd5:    load_data = {16'h0, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone select placement.
  always_comb begin
    mem_we    = accept && req_write && (req_fault == F_OK);
    byte_en   = 4'b0000;
    wdata_rep = req_wdata;
    unique case (req_func3[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = 4'b0011 << lane;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: byte_en = 4'b1111;
    endcase
  end

  // NOTE: the data array has no reset branch; only control state is reset, contents persist.
  always_ff @(posedge clock) begin
    for (int l = 0; l < 4; l++) begin
      if (mem_we && byte_en[l]) mem[word_idx][l] <= wdata_rep[l];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          fault_d = req_fault;
          rdata_d = (!req_write && (req_fault == F_OK)) ? load_data : 32'h0;
          if (LATENCY > 1) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      fault_q      <= F_OK;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      fault_q      <= fault_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: one LATENCY=1 instance and one LATENCY=4 instance
// sharing clock and reset.
module tb_data_mem_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [2:0]  req_func3  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic [1:0]  resp_fault [2];

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(1), .INIT_ZERO(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_func3(req_func3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0])
  );

  data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(4), .INIT_ZERO(1'b1)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_func3(req_func3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for resp_valid after an acceptance edge; returns negedges counted (1 = right after edge).
  task automatic wait_resp(input int i, output int n);
    n = 1;
    while (resp_valid[i] !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic txn(input int i, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic [1:0] exp_fault, input string tag);
    exp_t e;
    int   n;
    sb.push_back('{rdata: exp_rdata, fault: exp_fault});
    @(negedge clock);
    check({tag, ".req_ready"}, 32'(req_ready[i]), 32'd1);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_func3[i] = f3;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    @(negedge clock);
    req_valid[i] = 1'b0;
    wait_resp(i, n);
    check({tag, ".latency"}, 32'(n), 32'(lat_of(i)));
    e = sb.pop_front();
    check({tag, ".rdata"}, resp_rdata[i], e.rdata);
    check({tag, ".fault"}, 32'(resp_fault[i]), 32'(e.fault));
  endtask

  initial begin
    exp_t e;
    int   n;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_write[i]  = 1'b0;
      req_func3[i]  = 3'd0;
      req_addr[i]   = '0;
      req_wdata[i]  = '0;
      resp_ready[i] = 1'b1;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset%0d.req_ready", i), 32'(req_ready[i]), 32'd1);
      check($sformatf("reset%0d.resp_valid", i), 32'(resp_valid[i]), 32'd0);
      check($sformatf("reset%0d.rdata", i), resp_rdata[i], 32'h0);
      check($sformatf("reset%0d.fault", i), 32'(resp_fault[i]), 32'd0);
    end
    reset_n = 1'b1;

    // Basic store/load and extension behaviour on the LATENCY=1 instance.
    txn(0, 1'b1, 3'd2, 32'h10, 32'h8000_00FF, 32'h0, 2'd0, "sw_10");
    txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h8000_00FF, 2'd0, "lw_10");
    txn(0, 1'b0, 3'd0, 32'h10, 32'h0, 32'hFFFF_FFFF, 2'd0, "lb_10");
    txn(0, 1'b0, 3'd4, 32'h13, 32'h0, 32'h0000_0080, 2'd0, "lbu_13");
    txn(0, 1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF_8000, 2'd0, "lh_12");
    txn(0, 1'b0, 3'd5, 32'h12, 32'h0, 32'h0000_8000, 2'd0, "lhu_12");
    txn(0, 1'b0, 3'd1, 32'h10, 32'h0, 32'h0000_00FF, 2'd0, "lh_10");
    txn(0, 1'b0, 3'd0, 32'h11, 32'h0, 32'h0000_0000, 2'd0, "lb_11");

    // Partial stores carry junk in the upper bits that must not reach memory.
    txn(0, 1'b1, 3'd0, 32'h21, 32'hDEAD_BEAB, 32'h0, 2'd0, "sb_21");
    txn(0, 1'b1, 3'd1, 32'h22, 32'hCAFE_1234, 32'h0, 2'd0, "sh_22");
    txn(0, 1'b0, 3'd2, 32'h20, 32'h0, 32'h1234_AB00, 2'd0, "lw_20");
    txn(0, 1'b0, 3'd2, 32'h1C, 32'h0, 32'h0, 2'd0, "lw_1c");
    txn(0, 1'b0, 3'd2, 32'h24, 32'h0, 32'h0, 2'd0, "lw_24");

    // Faults and their priority.
    txn(0, 1'b0, 3'd2, 32'h02, 32'h0, 32'h0, 2'd1, "lw_02_mis");
    txn(0, 1'b1, 3'd1, 32'h05, 32'h0000_FFFF, 32'h0, 2'd1, "sh_05_mis");
    txn(0, 1'b0, 3'd2, 32'h04, 32'h0, 32'h0, 2'd0, "lw_04_unch");
    txn(0, 1'b0, 3'd2, 32'h1000, 32'h0, 32'h0, 2'd2, "lw_1000_rng");
    txn(0, 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 2'd3, "f3_3_ill");
    txn(0, 1'b1, 3'd4, 32'h10, 32'h0, 32'h0, 2'd3, "st_f3_4_ill");
    txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h8000_00FF, 2'd0, "lw_10_unch");
    txn(0, 1'b0, 3'd7, 32'h1001, 32'h0, 32'h0, 2'd3, "ill_over_rng");
    txn(0, 1'b0, 3'd1, 32'h1001, 32'h0, 32'h0, 2'd2, "rng_over_mis");
    txn(0, 1'b0, 3'd5, 32'h13, 32'h0, 32'h0, 2'd1, "lhu_13_mis");

    // LATENCY=4 instance: normal traffic, then a stalled response.
    txn(1, 1'b1, 3'd2, 32'h40, 32'h5A5A_C3C3, 32'h0, 2'd0, "l4_sw_40");
    txn(1, 1'b0, 3'd0, 32'h41, 32'h0, 32'hFFFF_FFC3, 2'd0, "l4_lb_41");

    sb.push_back('{rdata: 32'h5A5A_C3C3, fault: 2'd0});
    @(negedge clock);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_func3[1] = 3'd2;
    req_addr[1]  = 32'h40;
    @(negedge clock);
    req_valid[1]  = 1'b0;
    resp_ready[1] = 1'b0;
    wait_resp(1, n);
    check("stall.latency", 32'(n), 32'd4);
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("stall%0d.resp_valid", k), 32'(resp_valid[1]), 32'd1);
      check($sformatf("stall%0d.rdata", k), resp_rdata[1], e.rdata);
      check($sformatf("stall%0d.fault", k), 32'(resp_fault[1]), 32'(e.fault));
      check($sformatf("stall%0d.req_ready", k), 32'(req_ready[1]), 32'd0);
    end
    resp_ready[1] = 1'b1;
    @(negedge clock);
    check("stall.done.resp_valid", 32'(resp_valid[1]), 32'd0);
    check("stall.done.req_ready", 32'(req_ready[1]), 32'd1);

    // Reset during WAIT abandons the request.
    @(negedge clock);
    req_valid[1] = 1'b1;
    req_func3[1] = 3'd2;
    req_addr[1]  = 32'h40;
    @(negedge clock);
    req_valid[1] = 1'b0;
    check("rst_wait.in_wait", 32'(req_ready[1]), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_wait.resp_valid", 32'(resp_valid[1]), 32'd0);
    check("rst_wait.req_ready", 32'(req_ready[1]), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("rst_wait.no_resp", 32'(resp_valid[1]), 32'd0);
    txn(1, 1'b0, 3'd2, 32'h40, 32'h0, 32'h5A5A_C3C3, 2'd0, "l4_lw_after_rst");
    txn(0, 1'b0, 3'd2, 32'h20, 32'h0, 32'h1234_AB00, 2'd0, "lw_20_after_rst");

    check("scoreboard.empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
